intr_arb: RTL and testbench
===========================

Name: intr_arb

Overview:
- Interrupt arbiter/sequencer between the per-source interrupt capture block and the CPU/host.
- Takes the registered pending vector, applies the enable mask and selects one source (fixed priority; round-robin optional).
- Presents an irq/id request to the host and runs the claim (ack) / end-of-interrupt (eoi) handshake.
- Drives the capture block's clear strobe/select so the claimed source's pending bit is cleared exactly once.

Parameters:
- INTR_NUM, 8, number of interrupt sources (1..32).
- ID_W, 3, width of irq_id; must satisfy 2**ID_W >= INTR_NUM.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- intr_pend  input  INTR_NUM  registered pending vector from the capture block (its intr_sig).
- intr_en  input  INTR_NUM  per-source enable; 1 = eligible for arbitration.
- ack  input  1  host claims the presented interrupt; single-cycle pulse.
- eoi  input  1  host finished servicing; single-cycle pulse.
- irq  output  1  interrupt request to host.
- irq_id  output  ID_W  index of the presented/claimed source.
- busy  output  1  a claimed interrupt is in service.
- intr_clr  output  1  clear strobe to the capture block.
- intr_clr_sel  output  INTR_NUM  one-hot clear select to the capture block.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; round-robin pointer (if built) 0. A reset mid-handshake abandons the handshake silently. No clear is issued.
- eligible = intr_pend & intr_en.
- FSM states: IDLE, PRESENT, CLEAR, SERVICE. All outputs are registered.
- IDLE:
  - If eligible != 0: latch winner index into irq_id, set irq = 1, go to PRESENT.
  - irq rises on the first clk edge after eligible becomes nonzero (1-cycle latency).
- PRESENT:
  - irq = 1 and irq_id are held stable until ack. The selection is committed: later changes to intr_en or intr_pend do not alter irq_id or drop irq.
  - On ack: irq <= 0; intr_clr <= 1; intr_clr_sel <= one-hot(irq_id); busy <= 1; go to CLEAR.
  - eoi is ignored in PRESENT, including when it arrives in the same cycle as ack.
- CLEAR (exactly 1 cycle):
  - intr_clr = 1 with one-hot intr_clr_sel for this one cycle only; both return to 0 on the next edge.
  - Go to SERVICE.
  - A source edge that coincides with the clear cycle may be lost; keeping the strobe to one cycle keeps that window minimal.
- SERVICE:
  - busy = 1; irq = 0; irq_id holds the claimed id.
  - The claimed source may re-pend; it is captured in intr_pend and arbitrated after eoi.
  - On eoi: busy <= 0, go to IDLE. The earliest next irq is 1 cycle after return to IDLE.
  - eoi can arrive as early as the CLEAR cycle; it is then taken in that cycle: go directly to IDLE, busy <= 0.
- ack outside PRESENT and eoi outside SERVICE/CLEAR are ignored.
- Fixed priority: lowest index wins.
- Width rules:
  - irq_id is zero-extended from the winner index.
  - Bits of intr_en / intr_pend are only defined for indices < INTR_NUM.
  - INTR_NUM = 1 is legal; irq_id is then always 0.
- No nesting: at most one interrupt outstanding between ack and eoi.

Optional Feature:
- Macro: INTR_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Pointer p (ID_W bits) updates on ack to (irq_id + 1) mod INTR_NUM; it wraps from INTR_NUM-1 to 0.
  - Winner = first eligible index scanning p, p+1, …, wrapping to p-1.
- Not defined: fixed lowest-index priority; no pointer register.

Test Plan:
- Reset mid-handshake: assert rst while in PRESENT with irq = 1, irq_id = 5 → next cycle irq = 0, busy = 0, intr_clr = 0, intr_clr_sel = 0. After release, intr_pend = 8'h20 re-presents id 5 one cycle later.
- Basic claim: intr_pend = 8'h24, intr_en = 8'hFF.
  - → irq = 1, irq_id = 2 one cycle later.
  - ack → intr_clr = 1 and intr_clr_sel = 8'h04 for exactly one cycle; busy = 1.
  - eoi → busy = 0; with intr_pend = 8'h20, irq_id = 5 one cycle after returning to IDLE.
- Masking/commit:
  - intr_pend = 8'h01, intr_en = 8'h00 → irq stays 0 for 20 cycles.
  - Set intr_en = 8'h01 → irq = 1, id 0.
  - Clearing intr_en during PRESENT → irq and irq_id = 0 held until ack.
- Protocol violations:
  - eoi in PRESENT, and ack in SERVICE → no state change, no intr_clr.
  - ack and eoi in the same PRESENT cycle → the ack is taken and the eoi ignored; busy = 1.
- Re-pend during service: source 3 re-pends while busy → no irq until eoi; then irq_id = 3.
- INTR_ARB_RR_EN defined: intr_pend held at 8'h81 across repeated claims → irq_id sequence 0, 7, 0, 7. With the macro undefined, the sequence is 0, 0, 0.

Source files
------------

// File: rtl/intr_arb.sv
// intr_arb: interrupt arbiter / sequencer between the pending-capture block
// and the host. It picks one eligible source, presents irq/irq_id, runs the
// ack (claim) / eoi (end-of-interrupt) handshake, and pulses a one-cycle
// clear strobe with a one-hot select back to the capture block.
//
// Build option: define INTR_ARB_RR_EN for round-robin arbitration. Without
// it, arbitration is fixed priority (lowest index wins) and no pointer
// register exists.
module intr_arb #(
  parameter int INTR_NUM = 8,
  parameter int ID_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INTR_NUM-1:0] intr_pend,
  input  logic [INTR_NUM-1:0] intr_en,
  input  logic                ack,
  input  logic                eoi,
  output logic                irq,
  output logic [ID_W-1:0]     irq_id,
  output logic                busy,
  output logic                intr_clr,
  output logic [INTR_NUM-1:0] intr_clr_sel
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                irq_q, irq_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic                busy_q, busy_d;
  logic                clr_q, clr_d;
  logic [INTR_NUM-1:0] clr_sel_q, clr_sel_d;

  logic [INTR_NUM-1:0] eligible;
  logic                any_eligible;
  logic [ID_W-1:0]     winner;
  logic [INTR_NUM-1:0] id_onehot;

  assign eligible     = intr_pend & intr_en;
  assign any_eligible = |eligible;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [INTR_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = INTR_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = ID_W'(i);
      end
    end
  endfunction

  // One-hot decode of the presented id, used as the clear select on claim.
  for (genvar gi = 0; gi < INTR_NUM; gi++) begin : g_onehot
    assign id_onehot[gi] = (irq_id_q == ID_W'(gi));
  end

`ifdef INTR_ARB_RR_EN
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [INTR_NUM-1:0] upper_mask;
  logic [INTR_NUM-1:0] upper_elig;

  // Sources at or above the pointer are searched first; if none of them is
  // eligible the search wraps to the lowest eligible index overall.
  for (genvar gi = 0; gi < INTR_NUM; gi++) begin : g_rr_mask
    assign upper_mask[gi] = (ID_W'(gi) >= ptr_q);
  end

  assign upper_elig = eligible & upper_mask;

  // Round-robin winner selection starting at the pointer.
  always_comb begin
    if (|upper_elig) begin
      winner = lowest_idx(upper_elig);
    end else begin
      winner = lowest_idx(eligible);
    end
  end

  // Pointer advances past the claimed source, wrapping at INTR_NUM-1.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_PRESENT && ack) begin
      if (irq_id_q == ID_W'(INTR_NUM - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = irq_id_q + ID_W'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner = lowest_idx(eligible);
  end
`endif

  // Handshake sequencing; the clear strobe defaults low so it lasts one cycle.
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    busy_d    = busy_q;
    clr_d     = 1'b0;
    clr_sel_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          irq_d    = 1'b1;
          irq_id_d = winner;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Selection is committed here; only ack moves on, eoi is ignored.
        if (ack) begin
          irq_d     = 1'b0;
          clr_d     = 1'b1;
          clr_sel_d = id_onehot;
          busy_d    = 1'b1;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // An early eoi is honoured here so the host never has to wait.
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any handshake in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
      clr_q     <= 1'b0;
      clr_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      busy_q    <= busy_d;
      clr_q     <= clr_d;
      clr_sel_q <= clr_sel_d;
    end
  end

  assign irq          = irq_q;
  assign irq_id       = irq_id_q;
  assign busy         = busy_q;
  assign intr_clr     = clr_q;
  assign intr_clr_sel = clr_sel_q;

endmodule

// File: tb/tb_intr_arb.sv
// Testbench for intr_arb: directed handshake scenarios followed by random
// transactions. The driver pushes expected ids / clear selects into queues;
// a monitor pops and compares whenever irq rises or intr_clr fires.
module tb_intr_arb;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   intr_pend;
  logic [N-1:0]   intr_en;
  logic           ack;
  logic           eoi;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic           busy;
  logic           intr_clr;
  logic [N-1:0]   intr_clr_sel;

  intr_arb #(.INTR_NUM(N), .ID_W(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .intr_pend    (intr_pend),
    .intr_en      (intr_en),
    .ack          (ack),
    .eoi          (eoi),
    .irq          (irq),
    .irq_id       (irq_id),
    .busy         (busy),
    .intr_clr     (intr_clr),
    .intr_clr_sel (intr_clr_sel)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           exp_id_q[$];
  logic [N-1:0] exp_clr_q[$];
  int           ptr_m = 0;
  int           cur_id = 0;
  bit           presented = 1'b0;
  bit           done = 1'b0;

`ifdef INTR_ARB_RR_EN
  int seq_exp[4] = '{0, 7, 0, 7};
`else
  int seq_exp[4] = '{0, 0, 0, 0};
`endif

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: lowest set bit of the eligible vector, after
  // rotating it so the round-robin pointer lands on bit 0.
  function automatic int lowest(logic [N-1:0] v);
    logic [N-1:0] lb;
    lb = v & (~v + N'(1));
    return $clog2(lb);
  endfunction

  function automatic int ref_pick(logic [N-1:0] e);
`ifdef INTR_ARB_RR_EN
    logic [2*N-1:0] d;
    logic [N-1:0]   rot;
    d   = {e, e};
    rot = N'(d >> ptr_m);
    return (ptr_m + lowest(rot)) % N;
`else
    return lowest(e);
`endif
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_present();
    cur_id = ref_pick(intr_pend & intr_en);
    exp_id_q.push_back(cur_id);
  endtask

  // Make sources eligible from IDLE; irq must be up one edge later.
  task automatic present(logic [N-1:0] p, logic [N-1:0] e);
    intr_pend = p;
    intr_en   = e;
    expect_present();
    tick();
    chk("irq_latency", int'(irq), 1);
    presented = 1'b1;
  endtask

  task automatic claim(int waitc, bit early_eoi, bit glitch, bit eoi_too, logic [N-1:0] new_pend);
    for (int i = 0; i < waitc; i++) begin
      eoi = early_eoi && (i == 0);
      if (glitch) intr_en = N'($urandom);
      tick();
      chk("present_irq", int'(irq), 1);
      chk("present_busy", int'(busy), 0);
    end
    ack = 1'b1;
    eoi = eoi_too;
    exp_clr_q.push_back(N'(1) << cur_id);
    ptr_m = (cur_id + 1) % N;
    tick();
    ack       = 1'b0;
    eoi       = 1'b0;
    intr_pend = new_pend;
    presented = 1'b0;
    chk("busy_after_ack", int'(busy), 1);
    chk("irq_after_ack", int'(irq), 0);
  endtask

  task automatic finish(int delay, bit stray);
    for (int i = 0; i < delay; i++) begin
      ack = stray && (i == 1);
      tick();
      chk("service_busy", int'(busy), 1);
      chk("service_irq", int'(irq), 0);
    end
    ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("busy_after_eoi", int'(busy), 0);
    chk("irq_after_eoi", int'(irq), 0);
    if ((intr_pend & intr_en) != '0) begin
      expect_present();
      tick();
      chk("irq_reissue", int'(irq), 1);
      presented = 1'b1;
    end
  endtask

  task automatic random_txn();
    logic [N-1:0] p, e, np;
    int b;
    if (!presented) begin
      p = N'($urandom);
      e = N'($urandom);
      if ((p & e) == '0) begin
        b = $urandom_range(0, N - 1);
        p[b] = 1'b1;
        e[b] = 1'b1;
      end
      present(p, e);
    end
    np = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
    claim($urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, np);
    finish($urandom_range(0, 4), $urandom_range(0, 1) == 1);
  endtask

  initial begin
    fork
      // Monitor: compares on each irq rise and each clear strobe.
      begin : monitor
        bit prev_irq = 1'b0;
        bit prev_clr = 1'b0;
        int held_exp = 0;
        while (!done) begin
          @(negedge clk);
          if (rst) begin
            prev_irq = 1'b0;
            prev_clr = 1'b0;
          end else begin
            if (irq && !prev_irq) begin
              if (exp_id_q.size() == 0) begin
                chk("irq_unexpected", int'(irq), 0);
              end else begin
                held_exp = exp_id_q.pop_front();
                chk("irq_id", int'(irq_id), held_exp);
              end
            end else if (irq) begin
              chk("irq_id_hold", int'(irq_id), held_exp);
            end
            if (irq) chk("irq_busy_excl", int'(busy), 0);
            if (intr_clr) begin
              chk("clr_single", int'(prev_clr), 0);
              chk("busy_in_clr", int'(busy), 1);
              if (exp_clr_q.size() == 0) begin
                chk("clr_unexpected", int'(intr_clr), 0);
              end else begin
                chk("clr_sel", int'(intr_clr_sel), int'(exp_clr_q.pop_front()));
              end
            end else begin
              chk("clr_sel_idle", int'(intr_clr_sel), 0);
            end
            prev_irq = irq;
            prev_clr = intr_clr;
          end
        end
      end
      // Driver.
      begin : driver
        rst = 1'b1; ack = 1'b0; eoi = 1'b0; intr_pend = '0; intr_en = '0;
        repeat (3) tick();
        chk("rst_irq", int'(irq), 0);
        chk("rst_id", int'(irq_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clr", int'(intr_clr), 0);
        chk("rst_clr_sel", int'(intr_clr_sel), 0);
        rst = 1'b0;
        tick();

        // Basic claim: 0x24 -> id 2, clear select 0x04, then 0x20 -> id 5.
        present(8'h24, 8'hFF);
        chk("basic_id", int'(irq_id), 2);
        claim(2, 1'b0, 1'b0, 1'b0, 8'h20);
        finish(3, 1'b0);
        chk("basic_next_id", int'(irq_id), 5);
        claim(1, 1'b0, 1'b0, 1'b0, 8'h00);
        finish(0, 1'b0);

        // Masking, then commit with the enable dropped during PRESENT.
        intr_pend = 8'h01;
        intr_en   = 8'h00;
        for (int i = 0; i < 20; i++) begin
          tick();
          chk("masked_irq", int'(irq), 0);
        end
        present(8'h01, 8'h01);
        chk("unmask_id", int'(irq_id), 0);
        intr_en = 8'h00;
        tick();
        tick();
        chk("commit_irq", int'(irq), 1);
        chk("commit_id", int'(irq_id), 0);
        // eoi in PRESENT, then ack+eoi together, then stray ack in SERVICE.
        claim(2, 1'b1, 1'b0, 1'b1, 8'h00);
        finish(3, 1'b1);

        // Re-pend of source 3 while in service.
        present(8'h08, 8'hFF);
        claim(0, 1'b0, 1'b0, 1'b0, 8'h08);
        finish(4, 1'b0);
        chk("repend_id", int'(irq_id), 3);
        claim(0, 1'b0, 1'b0, 1'b0, 8'h00);
        finish(1, 1'b0);

        // Reset while presenting id 5 (checked before the next edge).
        present(8'h20, 8'hFF);
        chk("pre_rst_id", int'(irq_id), 5);
        rst = 1'b1;
        #2;
        chk("midrst_irq", int'(irq), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_clr", int'(intr_clr), 0);
        chk("midrst_clr_sel", int'(intr_clr_sel), 0);
        exp_id_q.delete();
        exp_clr_q.delete();
        ptr_m = 0;
        presented = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        present(8'h20, 8'hFF);
        chk("rst_reissue_id", int'(irq_id), 5);
        claim(0, 1'b0, 1'b0, 1'b0, 8'h00);
        finish(0, 1'b0);

        // Held 0x81 across repeated claims from a fresh pointer.
        intr_pend = '0;
        rst = 1'b1;
        ptr_m = 0;
        tick();
        rst = 1'b0;
        tick();
        present(8'h81, 8'hFF);
        for (int k = 0; k < 4; k++) begin
          chk("seq_id", int'(irq_id), seq_exp[k]);
          claim(1, 1'b0, 1'b0, 1'b0, (k == 3) ? 8'h00 : 8'h81);
          finish(1, 1'b0);
        end

        // Random transactions.
        for (int t = 0; t < 200; t++) begin
          random_txn();
        end
        if (presented) begin
          claim(0, 1'b0, 1'b0, 1'b0, 8'h00);
          finish(0, 1'b0);
        end
        tick();
        tick();
        chk("exp_id_drained", exp_id_q.size(), 0);
        chk("exp_clr_drained", exp_clr_q.size(), 0);
        done = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
